// File: rtl/vr_tx_arb.sv
// Round-robin arbiter sharing the single UDP TX metadata/data path among the VR engines.
// Optional VR_ARB_VC_PRIO_EN: source VC_SRC_IDX wins in IDLE and leaves the round-robin pointer alone.
module vr_tx_arb #(
   parameter int unsigned NOC_DATA_W     = 512,
   parameter int unsigned NOC_PADBYTES   = NOC_DATA_W / 8,
   parameter int unsigned NOC_PADBYTES_W = $clog2(NOC_PADBYTES),
   parameter int unsigned NUM_SRC        = 4,
   parameter int unsigned NUM_SRC_W      = $clog2(NUM_SRC),
   parameter int unsigned VC_SRC_IDX     = 2,
   parameter int unsigned UDP_INFO_W     = 96
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_SRC-1:0]                 src_arb_meta_val,
   input  logic [NUM_SRC*UDP_INFO_W-1:0]      src_arb_meta_info,
   output logic [NUM_SRC-1:0]                 arb_src_meta_rdy,
   input  logic [NUM_SRC-1:0]                 src_arb_data_val,
   input  logic [NUM_SRC*NOC_DATA_W-1:0]      src_arb_data,
   input  logic [NUM_SRC-1:0]                 src_arb_data_last,
   input  logic [NUM_SRC*NOC_PADBYTES_W-1:0]  src_arb_data_padbytes,
   output logic [NUM_SRC-1:0]                 arb_src_data_rdy,
   output logic                               arb_udp_meta_val,
   output logic [UDP_INFO_W-1:0]              arb_udp_meta_info,
   input  logic                               udp_arb_meta_rdy,
   output logic                               arb_udp_data_val,
   output logic [NOC_DATA_W-1:0]              arb_udp_data,
   output logic                               arb_udp_data_last,
   output logic [NOC_PADBYTES_W-1:0]          arb_udp_data_padbytes,
   input  logic                               udp_arb_data_rdy,
   output logic                               arb_busy
);

`ifdef VR_ARB_VC_PRIO_EN
   localparam bit PRIO_EN = 1'b1;
`else
   localparam bit PRIO_EN = 1'b0;
`endif
   localparam logic [NUM_SRC-1:0]   VC_MASK = NUM_SRC'(1) << VC_SRC_IDX;
   localparam logic [NUM_SRC_W-1:0] VC_IDX  = NUM_SRC_W'(VC_SRC_IDX);

   typedef enum logic [1:0] {StIdle, StMeta, StData} state_e;

   state_e               state_reg, state_next;
   logic [NUM_SRC_W-1:0] grant_reg, grant_next;
   logic [NUM_SRC_W-1:0] rr_ptr_reg, rr_ptr_next;

   logic                      found;
   logic [NUM_SRC_W-1:0]      pick;
   logic [NUM_SRC-1:0]        grant_oh;
   logic                      sel_meta_val;
   logic [UDP_INFO_W-1:0]     sel_meta_info;
   logic                      sel_data_val;
   logic [NOC_DATA_W-1:0]     sel_data;
   logic                      sel_last;
   logic [NOC_PADBYTES_W-1:0] sel_pad;

   // Operands are always below NUM_SRC, so one conditional subtract gives the modulo.
   function automatic logic [NUM_SRC_W-1:0] wrap_add(input logic [NUM_SRC_W-1:0] base,
                                                     input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NUM_SRC) s = s - NUM_SRC;
      return NUM_SRC_W'(s);
   endfunction

   always_comb begin
      found = 1'b0;
      pick  = rr_ptr_reg;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (!found && src_arb_meta_val[wrap_add(rr_ptr_reg, i)]) begin
            found = 1'b1;
            pick  = wrap_add(rr_ptr_reg, i);
         end
      end
      if (PRIO_EN && |(src_arb_meta_val & VC_MASK)) begin
         found = 1'b1;
         pick  = VC_IDX;
      end
   end

   // An out-of-range grant matches no source, so every mux yields 0.
   always_comb begin
      grant_oh      = '0;
      sel_meta_val  = 1'b0;
      sel_meta_info = '0;
      sel_data_val  = 1'b0;
      sel_data      = '0;
      sel_last      = 1'b0;
      sel_pad       = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (grant_reg == NUM_SRC_W'(i)) begin
            grant_oh[i]   = 1'b1;
            sel_meta_val  = src_arb_meta_val[i];
            sel_meta_info = src_arb_meta_info[i*UDP_INFO_W +: UDP_INFO_W];
            sel_data_val  = src_arb_data_val[i];
            sel_data      = src_arb_data[i*NOC_DATA_W +: NOC_DATA_W];
            sel_last      = src_arb_data_last[i];
            sel_pad       = src_arb_data_padbytes[i*NOC_PADBYTES_W +: NOC_PADBYTES_W];
         end
      end
   end

   always_comb begin
      state_next            = state_reg;
      grant_next            = grant_reg;
      rr_ptr_next           = rr_ptr_reg;
      arb_src_meta_rdy      = '0;
      arb_src_data_rdy      = '0;
      arb_udp_meta_val      = 1'b0;
      arb_udp_meta_info     = '0;
      arb_udp_data_val      = 1'b0;
      arb_udp_data          = '0;
      arb_udp_data_last     = 1'b0;
      arb_udp_data_padbytes = '0;
      unique case (state_reg)
         StIdle: begin
            if (found) begin
               grant_next = pick;
               state_next = StMeta;
            end
         end
         StMeta: begin
            arb_udp_meta_val  = sel_meta_val;
            arb_udp_meta_info = sel_meta_info;
            arb_src_meta_rdy  = grant_oh & {NUM_SRC{udp_arb_meta_rdy}};
            if (sel_meta_val && udp_arb_meta_rdy) state_next = StData;
         end
         StData: begin
            arb_udp_data_val      = sel_data_val;
            arb_udp_data          = sel_data;
            arb_udp_data_last     = sel_last;
            arb_udp_data_padbytes = sel_pad;
            arb_src_data_rdy      = grant_oh & {NUM_SRC{udp_arb_data_rdy}};
            if (sel_data_val && udp_arb_data_rdy && sel_last) begin
               state_next = StIdle;
               // A priority-won message must not disturb the round-robin order.
               if (!(PRIO_EN && grant_reg == VC_IDX)) rr_ptr_next = wrap_add(grant_reg, 1);
            end
         end
         default: state_next = StIdle;
      endcase
   end

   assign arb_busy = (state_reg != StIdle);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= StIdle;
         grant_reg  <= '0;
         rr_ptr_reg <= '0;
      end else begin
         state_reg  <= state_next;
         grant_reg  <= grant_next;
         rr_ptr_reg <= rr_ptr_next;
      end
   end

endmodule

// File: tb/tb_vr_tx_arb.sv
// Directed self-checking bench for vr_tx_arb (64-bit beats, 32-bit metadata).
// Expected grant order for the priority scenario follows VR_ARB_VC_PRIO_EN.
module tb_vr_tx_arb;
   localparam int unsigned DW = 64;
   localparam int unsigned PW = 3;
   localparam int unsigned IW = 32;
   localparam int unsigned NS = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [NS-1:0]    src_meta_val;
   logic [NS*IW-1:0] src_meta_info;
   logic [NS-1:0]    meta_rdy;
   logic [NS-1:0]    src_data_val;
   logic [NS*DW-1:0] src_data;
   logic [NS-1:0]    src_last;
   logic [NS*PW-1:0] src_pad;
   logic [NS-1:0]    data_rdy;
   logic             udp_meta_val;
   logic [IW-1:0]    udp_meta_info;
   logic             udp_meta_rdy;
   logic             udp_data_val;
   logic [DW-1:0]    udp_data;
   logic             udp_last;
   logic [PW-1:0]    udp_pad;
   logic             udp_data_rdy;
   logic             busy;

   int checks = 0;
   int errors = 0;

   vr_tx_arb #(
      .NOC_DATA_W (DW),
      .NUM_SRC    (NS),
      .VC_SRC_IDX (2),
      .UDP_INFO_W (IW)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .src_arb_meta_val      (src_meta_val),
      .src_arb_meta_info     (src_meta_info),
      .arb_src_meta_rdy      (meta_rdy),
      .src_arb_data_val      (src_data_val),
      .src_arb_data          (src_data),
      .src_arb_data_last     (src_last),
      .src_arb_data_padbytes (src_pad),
      .arb_src_data_rdy      (data_rdy),
      .arb_udp_meta_val      (udp_meta_val),
      .arb_udp_meta_info     (udp_meta_info),
      .udp_arb_meta_rdy      (udp_meta_rdy),
      .arb_udp_data_val      (udp_data_val),
      .arb_udp_data          (udp_data),
      .arb_udp_data_last     (udp_last),
      .arb_udp_data_padbytes (udp_pad),
      .udp_arb_data_rdy      (udp_data_rdy),
      .arb_busy              (busy)
   );

   function automatic logic [IW-1:0] info_of(input int s);
      return 32'h1A00_0000 | 32'(s);
   endfunction

   function automatic logic [DW-1:0] beat_of(input int s, input int b);
      return 64'hD000_0000_0000_0000 | (64'(s) << 8) | 64'(b);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      src_meta_val  = '0;
      src_meta_info = '0;
      src_data_val  = '0;
      src_data      = '0;
      src_last      = '0;
      src_pad       = '0;
      udp_meta_rdy  = 1'b1;
      udp_data_rdy  = 1'b1;
   endtask

   task automatic set_meta(input int s, input logic v);
      src_meta_val[s]           = v;
      src_meta_info[s*IW +: IW] = info_of(s);
   endtask

   task automatic set_data(input int s, input logic v, input int b, input logic l,
                           input logic [PW-1:0] p);
      src_data_val[s]      = v;
      src_data[s*DW +: DW] = beat_of(s, b);
      src_last[s]          = l;
      src_pad[s*PW +: PW]  = p;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      rst = 1'b0;
   endtask

   // Single-beat message from source s, leaving the arbiter in IDLE afterwards.
   task automatic send_one(input int s);
      set_meta(s, 1'b1);
      tick();
      tick();
      set_meta(s, 1'b0);
      set_data(s, 1'b1, 0, 1'b1, '0);
      tick();
      set_data(s, 1'b0, 0, 1'b0, '0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      src_meta_val = '1;
      tick();
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (meta_rdy !== 4'b0) begin errors++; $display("FAIL reset_meta_rdy: got %b want 0000", meta_rdy); end
      checks++; if (data_rdy !== 4'b0) begin errors++; $display("FAIL reset_data_rdy: got %b want 0000", data_rdy); end
      checks++; if (udp_meta_val !== 1'b0) begin errors++; $display("FAIL reset_meta_val: got %b want 0", udp_meta_val); end
      checks++; if (udp_data_val !== 1'b0) begin errors++; $display("FAIL reset_data_val: got %b want 0", udp_data_val); end
      rst = 1'b0;
      idle_inputs();
   endtask

   task automatic test_single_source();
      do_reset();
      set_meta(1, 1'b1);
      #1;
      checks++; if (udp_meta_val !== 1'b0) begin errors++; $display("FAIL single_meta_latency: got %b want 0", udp_meta_val); end
      tick();
      #1;
      checks++; if (udp_meta_val !== 1'b1) begin errors++; $display("FAIL single_meta_val: got %b want 1", udp_meta_val); end
      checks++; if (udp_meta_info !== info_of(1)) begin errors++; $display("FAIL single_meta_info: got %h want %h", udp_meta_info, info_of(1)); end
      checks++; if (meta_rdy !== 4'b0010) begin errors++; $display("FAIL single_meta_rdy: got %b want 0010", meta_rdy); end
      tick();
      set_meta(1, 1'b0);
      for (int b = 0; b < 3; b++) begin
         set_data(1, 1'b1, b, (b == 2), (b == 2) ? 3'd5 : 3'd0);
         #1;
         checks++; if (udp_data !== beat_of(1, b)) begin errors++; $display("FAIL single_data%0d: got %h want %h", b, udp_data, beat_of(1, b)); end
         checks++; if (udp_last !== (b == 2)) begin errors++; $display("FAIL single_last%0d: got %b want %b", b, udp_last, (b == 2)); end
         checks++; if (data_rdy !== 4'b0010) begin errors++; $display("FAIL single_data_rdy%0d: got %b want 0010", b, data_rdy); end
         if (b == 2) begin
            checks++; if (udp_pad !== 3'd5) begin errors++; $display("FAIL single_pad: got %0d want 5", udp_pad); end
         end
         tick();
      end
      set_data(1, 1'b0, 0, 1'b0, '0);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b want 0", busy); end
      // Pointer is now 2: of sources 0 and 2, source 2 wins.
      set_meta(0, 1'b1);
      set_meta(2, 1'b1);
      tick();
      #1;
      checks++; if (meta_rdy !== 4'b0100) begin errors++; $display("FAIL single_rr_ptr: got %b want 0100", meta_rdy); end
   endtask

   task automatic test_round_robin();
      int exp_order[5] = '{0, 1, 2, 3, 0};
      do_reset();
      for (int s = 0; s < 4; s++) begin
         set_meta(s, 1'b1);
         set_data(s, 1'b1, 0, 1'b1, '0);
      end
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_gap%0d: got busy %b want 0", k, busy); end
         tick();
         #1;
         checks++; if (meta_rdy !== 4'(1 << exp_order[k])) begin errors++; $display("FAIL rr_meta_rdy%0d: got %b want %b", k, meta_rdy, 4'(1 << exp_order[k])); end
         checks++; if (udp_meta_info !== info_of(exp_order[k])) begin errors++; $display("FAIL rr_info%0d: got %h want %h", k, udp_meta_info, info_of(exp_order[k])); end
         checks++; if (data_rdy !== 4'b0) begin errors++; $display("FAIL rr_data_rdy_meta%0d: got %b want 0000", k, data_rdy); end
         tick();
         #1;
         checks++; if (data_rdy !== 4'(1 << exp_order[k])) begin errors++; $display("FAIL rr_data_rdy%0d: got %b want %b", k, data_rdy, 4'(1 << exp_order[k])); end
         checks++; if (udp_data !== beat_of(exp_order[k], 0)) begin errors++; $display("FAIL rr_data%0d: got %h want %h", k, udp_data, beat_of(exp_order[k], 0)); end
         tick();
      end
   endtask

   task automatic test_backpressure();
      int b = 0;
      int sink_cnt = 0;
      do_reset();
      udp_meta_rdy = 1'b0;
      set_meta(0, 1'b1);
      tick();
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++; if (udp_meta_val !== 1'b1 || meta_rdy !== 4'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_meta_hold%0d: got val %b rdy %b busy %b want 1 0000 1", c, udp_meta_val, meta_rdy, busy); end
         tick();
      end
      udp_meta_rdy = 1'b1;
      #1;
      checks++; if (meta_rdy !== 4'b0001) begin errors++; $display("FAIL bp_meta_rdy: got %b want 0001", meta_rdy); end
      tick();
      set_meta(0, 1'b0);
      for (int c = 0; c < 8; c++) begin
         udp_data_rdy = (c % 2 == 1);
         set_data(0, 1'b1, b, (b == 3), '0);
         #1;
         checks++; if (udp_data !== beat_of(0, b) || udp_last !== (b == 3)) begin errors++; $display("FAIL bp_beat%0d: got %h/%b want %h/%b", c, udp_data, udp_last, beat_of(0, b), (b == 3)); end
         checks++; if (data_rdy !== (udp_data_rdy ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL bp_data_rdy%0d: got %b want %b", c, data_rdy, udp_data_rdy ? 4'b0001 : 4'b0000); end
         if (udp_data_val && udp_data_rdy) sink_cnt++;
         if (udp_data_rdy) b++;
         tick();
      end
      set_data(0, 1'b0, 0, 1'b0, '0);
      udp_data_rdy = 1'b1;
      #1;
      checks++; if (sink_cnt != 4) begin errors++; $display("FAIL bp_beat_count: got %0d want 4", sink_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_end_idle: got busy %b want 0", busy); end
   endtask

   task automatic test_early_data();
      do_reset();
      udp_meta_rdy = 1'b0;
      set_meta(3, 1'b1);
      set_data(3, 1'b1, 0, 1'b1, 3'd7);
      #1;
      checks++; if (data_rdy !== 4'b0 || udp_data_val !== 1'b0) begin errors++; $display("FAIL early_idle: got rdy %b val %b want 0000 0", data_rdy, udp_data_val); end
      tick();
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++; if (data_rdy !== 4'b0 || udp_data_val !== 1'b0) begin errors++; $display("FAIL early_meta%0d: got rdy %b val %b want 0000 0", c, data_rdy, udp_data_val); end
         tick();
      end
      udp_meta_rdy = 1'b1;
      #1;
      checks++; if (meta_rdy !== 4'b1000 || data_rdy !== 4'b0) begin errors++; $display("FAIL early_handshake: got meta %b data %b want 1000 0000", meta_rdy, data_rdy); end
      tick();
      set_meta(3, 1'b0);
      #1;
      checks++; if (data_rdy !== 4'b1000) begin errors++; $display("FAIL early_data_rdy: got %b want 1000", data_rdy); end
      checks++; if (udp_pad !== 3'd7 || udp_data !== beat_of(3, 0)) begin errors++; $display("FAIL early_data: got %h pad %0d want %h pad 7", udp_data, udp_pad, beat_of(3, 0)); end
      tick();
      set_data(3, 1'b0, 0, 1'b0, '0);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL early_end: got busy %b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_one(2);
      set_meta(2, 1'b1);
      tick();
      tick();
      set_meta(2, 1'b0);
      set_data(2, 1'b1, 0, 1'b0, '0);
      tick();
      set_data(2, 1'b1, 1, 1'b0, '0);
      rst = 1'b1;
      #1;
      checks++; if (udp_data !== beat_of(2, 1)) begin errors++; $display("FAIL mid_beat2: got %h want %h", udp_data, beat_of(2, 1)); end
      tick();
      rst = 1'b0;
      set_data(2, 1'b0, 0, 1'b0, '0);
      #1;
      checks++; if (busy !== 1'b0 || meta_rdy !== 4'b0 || data_rdy !== 4'b0) begin errors++; $display("FAIL mid_rdy: got busy %b meta %b data %b want 0 0000 0000", busy, meta_rdy, data_rdy); end
      checks++; if (udp_meta_val !== 1'b0 || udp_data_val !== 1'b0) begin errors++; $display("FAIL mid_val: got meta %b data %b want 0 0", udp_meta_val, udp_data_val); end
      set_meta(0, 1'b1);
      set_meta(3, 1'b1);
      tick();
      #1;
      checks++; if (meta_rdy !== 4'b0001) begin errors++; $display("FAIL mid_ptr_cleared: got %b want 0001", meta_rdy); end
   endtask

   task automatic test_vc_prio();
`ifdef VR_ARB_VC_PRIO_EN
      int exp_order[2] = '{2, 3};
`else
      int exp_order[2] = '{3, 2};
`endif
      do_reset();
      send_one(2);
      set_meta(2, 1'b1);
      set_meta(3, 1'b1);
      set_data(2, 1'b1, 0, 1'b1, '0);
      set_data(3, 1'b1, 0, 1'b1, '0);
      for (int k = 0; k < 2; k++) begin
         tick();
         #1;
         checks++; if (meta_rdy !== 4'(1 << exp_order[k])) begin errors++; $display("FAIL prio_meta%0d: got %b want %b", k, meta_rdy, 4'(1 << exp_order[k])); end
         tick();
         set_meta(exp_order[k], 1'b0);
         #1;
         checks++; if (data_rdy !== 4'(1 << exp_order[k])) begin errors++; $display("FAIL prio_data%0d: got %b want %b", k, data_rdy, 4'(1 << exp_order[k])); end
         tick();
         set_data(exp_order[k], 1'b0, 0, 1'b0, '0);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_single_source();
      test_round_robin();
      test_backpressure();
      test_early_data();
      test_reset_mid();
      test_vc_prio();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
